riscv_fetch_unit: RTL and testbench
===================================

RISCV_FETCH_UNIT -- requirements
Module: riscv_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL set the PC loaded on reset.
REQ-002 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 Port branch_taken_i  input  1  SHALL be the branch outcome from branch control for the instruction currently presented.
REQ-005 Port jump_i  input  1  SHALL flag an unconditional jump (JAL/JALR) for the instruction currently presented.
REQ-006 Port target_pc_i  input  32  SHALL be the redirect target for branch or jump.
REQ-007 Port imem_req_o  output  1  SHALL request an instruction-memory read.
REQ-008 Port imem_addr_o  output  32  SHALL be the read address, valid while imem_req_o=1.
REQ-009 Port imem_gnt_i  input  1  SHALL accept the request in the cycle it is high with imem_req_o=1.
REQ-010 Port imem_rvalid_i  input  1  SHALL mark imem_rdata_i valid.
REQ-011 Port imem_rdata_i  input  32  SHALL be the returned instruction word.
REQ-012 Port instr_valid_o  output  1  SHALL mark instr_o/pc_o valid to decode.
REQ-013 Port instr_ready_i  input  1  SHALL be decode's accept; a handshake is instr_valid_o & instr_ready_i.
REQ-014 Port instr_o  output  32  SHALL be the held instruction word.
REQ-015 Port pc_o  output  32  SHALL be the address of instr_o.
REQ-016 Port misaligned_o  output  1  SHALL flag a redirect to a non-word-aligned target.

Function
REQ-017 The FSM SHALL have states IDLE, REQ, WAIT, HOLD, FAULT, with at most one outstanding memory read.
REQ-018 IDLE SHALL drive imem_req_o=0 and transition to REQ on the next edge unconditionally.
REQ-019 REQ SHALL drive imem_req_o=1 with imem_addr_o=pc; on imem_gnt_i=1 it transitions to WAIT, otherwise it stays in REQ with the address held stable.
REQ-020 WAIT SHALL drive imem_req_o=0; on imem_rvalid_i=1 it captures imem_rdata_i into instr_o and pc into pc_o, then transitions to HOLD.
REQ-021 imem_rvalid_i outside WAIT SHALL be ignored; response latency is one or more cycles after the grant.
REQ-022 HOLD SHALL drive instr_valid_o=1 with instr_o/pc_o stable until the handshake; instr_valid_o is 0 in every other state.
REQ-023 On a HOLD handshake with branch_taken_i|jump_i=0, the FSM SHALL set pc<=pc+4 and transition to REQ.
REQ-024 On a HOLD handshake with branch_taken_i|jump_i=1 and target_pc_i[1:0]==2'b00, the FSM SHALL set pc<=target_pc_i and transition to REQ.
REQ-025 On a HOLD handshake with redirect and target_pc_i[1:0]!=2'b00, the FSM SHALL leave pc unchanged, set misaligned_o=1 and transition to FAULT.
REQ-026 branch_taken_i, jump_i and target_pc_i SHALL be sampled only at a HOLD handshake and ignored otherwise.
REQ-027 FAULT SHALL be terminal until reset: imem_req_o=0, instr_valid_o=0, misaligned_o=1.
REQ-028 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-029 Minimum throughput SHALL be one instruction per 3 cycles (REQ->WAIT->HOLD) with immediate grant, one-cycle response and immediate ready.

Reset
REQ-030 Reset assertion SHALL immediately force state=IDLE, pc=RESET_PC, imem_req_o=0, imem_addr_o=RESET_PC, instr_valid_o=0, instr_o=0, pc_o=0, misaligned_o=0, regardless of any outstanding read.
REQ-031 A memory response for a read issued before reset SHALL NOT be captured after reset deasserts, because the FSM is not in WAIT.

Verification
REQ-032 Reset release, gnt=1, rvalid one cycle after gnt, data 32'h0000_0013, ready=1 -> imem_addr_o=0 then 4 then 8; pc_o/instr_o=0/0x13 on the first handshake.
REQ-033 HOLD with pc_o=32'h100, instr_ready_i=0 for 5 cycles -> instr_valid_o=1 and instr_o/pc_o unchanged throughout; no new imem_req_o.
REQ-034 Handshake at pc 32'h100 with branch_taken_i=1, target 32'h40 -> next imem_addr_o=32'h40; branch_taken_i=1 with ready=0 -> ignored.
REQ-035 jump_i=1, target 32'h42 at a handshake -> misaligned_o=1, FSM in FAULT, imem_req_o=0 until reset.
REQ-036 imem_gnt_i low for 3 cycles in REQ -> imem_addr_o stable; pc 32'hFFFF_FFFC with no redirect -> next address 32'h0.
REQ-037 Reset asserted in WAIT, rvalid pulsed after release before the first grant -> response ignored; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/riscv_fetch_unit.sv
// Instruction fetch unit: one outstanding imem read, holds the fetched word until decode
// accepts it, then advances sequentially or redirects to a branch/jump target.
module riscv_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        branch_taken_i,
    input  logic        jump_i,
    input  logic [31:0] target_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        misaligned_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_FAULT
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] pc_out_q;
    logic        req_q;
    logic        valid_q;
    logic        misaligned_q;

    logic        redirect;
    logic        target_aligned;
    logic [31:0] pc_plus4;

    assign redirect       = branch_taken_i | jump_i;
    assign target_aligned = (target_pc_i[1:0] == 2'b00);
    assign pc_plus4       = pc_q + 32'd4;

    // Outputs are registered alongside the state so they never glitch on transitions.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            instr_q      <= '0;
            pc_out_q     <= '0;
            req_q        <= 1'b0;
            valid_q      <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q <= S_REQ;
                    req_q   <= 1'b1;
                end
                S_REQ: begin
                    if (imem_gnt_i) begin
                        state_q <= S_WAIT;
                        req_q   <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid_i) begin
                        instr_q  <= imem_rdata_i;
                        pc_out_q <= pc_q;
                        valid_q  <= 1'b1;
                        state_q  <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (instr_ready_i) begin
                        valid_q <= 1'b0;
                        if (!redirect) begin
                            pc_q    <= pc_plus4;
                            req_q   <= 1'b1;
                            state_q <= S_REQ;
                        end else if (target_aligned) begin
                            pc_q    <= target_pc_i;
                            req_q   <= 1'b1;
                            state_q <= S_REQ;
                        end else begin
                            // Misaligned redirect: freeze pc and park until reset.
                            misaligned_q <= 1'b1;
                            state_q      <= S_FAULT;
                        end
                    end
                end
                S_FAULT: begin
                    req_q        <= 1'b0;
                    valid_q      <= 1'b0;
                    misaligned_q <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req_o    = req_q;
    assign imem_addr_o   = pc_q;
    assign instr_valid_o = valid_q;
    assign instr_o       = instr_q;
    assign pc_o          = pc_out_q;
    assign misaligned_o  = misaligned_q;

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Randomized bench for riscv_fetch_unit: the bench plays instruction memory and decode,
// and predicts the fetch address stream from the control-flow rules.
module tb_riscv_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        branch_taken_i, jump_i;
    logic [31:0] target_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i, imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        instr_valid_o, instr_ready_i;
    logic [31:0] instr_o, pc_o;
    logic        misaligned_o;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_pc;

    riscv_fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset),
        .branch_taken_i(branch_taken_i), .jump_i(jump_i), .target_pc_i(target_pc_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
        .instr_o(instr_o), .pc_o(pc_o), .misaligned_o(misaligned_o)
    );

    always #5 clk = ~clk;

    // Memory image: word at 0 is a NOP (0x13), other words are address-derived.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h0000_0013 + (a << 8);
    endfunction

    // Drives one full fetch: wait for request, grant after gnt_dly, respond after rsp_dly,
    // stall decode for rdy_dly cycles (with junk redirect inputs), then hand shake.
    task automatic do_fetch(input int gnt_dly, input int rsp_dly, input int rdy_dly,
                            input logic br, input logic jp, input logic [31:0] tgt,
                            output logic [31:0] addr, output logic [31:0] pco,
                            output logic [31:0] ins, output bit tmo, output bit stable);
        tmo = 0; stable = 1; addr = '0; pco = '0; ins = '0;
        for (int i = 0; i < 20 && imem_req_o !== 1'b1; i++) begin @(posedge clk); #1; end
        if (imem_req_o !== 1'b1) begin tmo = 1; return; end
        addr = imem_addr_o;
        repeat (gnt_dly) begin
            @(posedge clk); #1;
            if (imem_req_o !== 1'b1 || imem_addr_o !== addr) stable = 0;
        end
        imem_gnt_i = 1'b1; @(posedge clk); #1; imem_gnt_i = 1'b0;
        if (imem_req_o !== 1'b0) stable = 0;
        repeat (rsp_dly) begin @(posedge clk); #1; if (imem_req_o !== 1'b0) stable = 0; end
        imem_rvalid_i = 1'b1; imem_rdata_i = mem_word(addr);
        @(posedge clk); #1;
        imem_rvalid_i = 1'b0; imem_rdata_i = $urandom;
        for (int i = 0; i < 20 && instr_valid_o !== 1'b1; i++) begin @(posedge clk); #1; end
        if (instr_valid_o !== 1'b1) begin tmo = 1; return; end
        pco = pc_o; ins = instr_o;
        repeat (rdy_dly) begin
            branch_taken_i = 1'b1; jump_i = 1'($urandom); target_pc_i = $urandom;
            @(posedge clk); #1;
            if (instr_valid_o !== 1'b1 || pc_o !== pco || instr_o !== ins || imem_req_o !== 1'b0)
                stable = 0;
        end
        branch_taken_i = br; jump_i = jp; target_pc_i = tgt; instr_ready_i = 1'b1;
        @(posedge clk); #1;
        instr_ready_i = 1'b0; branch_taken_i = 1'b0; jump_i = 1'b0; target_pc_i = $urandom;
        if (instr_valid_o !== 1'b0) stable = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1; branch_taken_i = 0; jump_i = 0; target_pc_i = 0;
        imem_gnt_i = 0; imem_rvalid_i = 0; imem_rdata_i = 0; instr_ready_i = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        n_checks++; if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_req got=%b exp=0", imem_req_o); end
        n_checks++; if (imem_addr_o !== RESET_PC) begin n_fail++; $display("FAIL reset_addr got=%h exp=%h", imem_addr_o, RESET_PC); end
        n_checks++; if (instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", instr_valid_o); end
        n_checks++; if (instr_o !== 32'h0 || pc_o !== 32'h0) begin n_fail++; $display("FAIL reset_instr_pc got=%h/%h exp=0/0", instr_o, pc_o); end
        n_checks++; if (misaligned_o !== 1'b0) begin n_fail++; $display("FAIL reset_misaligned got=%b exp=0", misaligned_o); end
        @(posedge clk); #1 reset = 1'b0;
        exp_pc = RESET_PC;
        $display("test_reset done");
    endtask

    task automatic test_sequential();
        logic [31:0] a, p, w; bit tmo, st;
        for (int k = 0; k < 3; k++) begin
            do_fetch(0, 0, 0, 1'b0, 1'b0, 32'h0, a, p, w, tmo, st);
            n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL seq_timeout k=%0d", k); end
            n_checks++; if (a !== exp_pc) begin n_fail++; $display("FAIL seq_addr got=%h exp=%h", a, exp_pc); end
            n_checks++; if (p !== exp_pc || w !== mem_word(exp_pc)) begin n_fail++; $display("FAIL seq_pc_instr got=%h/%h exp=%h/%h", p, w, exp_pc, mem_word(exp_pc)); end
            $display("seq fetch addr=%h pc_o=%h instr=%h", a, p, w);
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    task automatic test_hold_branch();
        logic [31:0] a, p, w; bit tmo, st;
        do_fetch(0, 0, 0, 1'b1, 1'b0, 32'h100, a, p, w, tmo, st);
        exp_pc = 32'h100;
        do_fetch(0, 0, 5, 1'b1, 1'b0, 32'h40, a, p, w, tmo, st);
        n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL hold_timeout"); end
        n_checks++; if (p !== 32'h100 || w !== mem_word(32'h100)) begin n_fail++; $display("FAIL hold_pc_instr got=%h/%h exp=%h/%h", p, w, 32'h100, mem_word(32'h100)); end
        n_checks++; if (st !== 1'b1) begin n_fail++; $display("FAIL hold_stable got=%b exp=1", st); end
        exp_pc = 32'h40;
        #0;
        for (int i = 0; i < 20 && imem_req_o !== 1'b1; i++) begin @(posedge clk); #1; end
        n_checks++; if (imem_addr_o !== exp_pc) begin n_fail++; $display("FAIL branch_addr got=%h exp=%h", imem_addr_o, exp_pc); end
        $display("hold/branch pc_o=%h next_addr=%h", p, imem_addr_o);
    endtask

    task automatic test_gnt_wrap();
        logic [31:0] a, p, w; bit tmo, st;
        do_fetch(3, 1, 0, 1'b0, 1'b1, 32'hFFFF_FFFC, a, p, w, tmo, st);
        n_checks++; if (a !== exp_pc || st !== 1'b1) begin n_fail++; $display("FAIL gnt_stall got=%h stable=%b exp=%h stable=1", a, st, exp_pc); end
        exp_pc = 32'hFFFF_FFFC;
        do_fetch(0, 0, 0, 1'b0, 1'b0, 32'h0, a, p, w, tmo, st);
        n_checks++; if (a !== 32'hFFFF_FFFC || p !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_top got=%h/%h exp=fffffffc", a, p); end
        exp_pc = exp_pc + 32'd4;
        do_fetch(0, 0, 0, 1'b0, 1'b0, 32'h0, a, p, w, tmo, st);
        n_checks++; if (a !== 32'h0 || w !== mem_word(32'h0)) begin n_fail++; $display("FAIL wrap_addr got=%h/%h exp=0/%h", a, w, mem_word(32'h0)); end
        $display("wrap fetch addr=%h instr=%h", a, w);
        exp_pc = exp_pc + 32'd4;
    endtask

    task automatic test_random();
        logic [31:0] a, p, w, tgt; bit tmo, st; logic br, jp;
        for (int k = 0; k < 40; k++) begin
            br  = ($urandom_range(0, 7) == 0);
            jp  = ($urandom_range(0, 7) == 0);
            tgt = $urandom & 32'hFFFF_FFFC;
            do_fetch($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                     br, jp, tgt, a, p, w, tmo, st);
            n_checks++;
            if (tmo !== 1'b0 || st !== 1'b1 || a !== exp_pc || p !== exp_pc || w !== mem_word(exp_pc)) begin
                n_fail++;
                $display("FAIL rand_fetch k=%0d got addr=%h pc=%h instr=%h tmo=%b stable=%b exp addr/pc=%h instr=%h",
                         k, a, p, w, tmo, st, exp_pc, mem_word(exp_pc));
            end
            $display("rand k=%0d addr=%h br=%b jp=%b tgt=%h", k, a, br, jp, tgt);
            exp_pc = (br | jp) ? tgt : exp_pc + 32'd4;
        end
    endtask

    task automatic test_reset_in_wait();
        logic [31:0] a, p, w; bit tmo, st;
        for (int i = 0; i < 20 && imem_req_o !== 1'b1; i++) begin @(posedge clk); #1; end
        imem_gnt_i = 1'b1; @(posedge clk); #1; imem_gnt_i = 1'b0;
        #2 reset = 1'b1;
        #1;
        n_checks++; if (imem_req_o !== 1'b0 || imem_addr_o !== RESET_PC) begin n_fail++; $display("FAIL wait_reset got req=%b addr=%h exp 0/%h", imem_req_o, imem_addr_o, RESET_PC); end
        @(posedge clk); #1 reset = 1'b0;
        imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF;
        repeat (2) begin @(posedge clk); #1; end
        imem_rvalid_i = 1'b0;
        n_checks++; if (instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL stale_rvalid got valid=%b exp=0", instr_valid_o); end
        exp_pc = RESET_PC;
        do_fetch(1, 1, 0, 1'b0, 1'b0, 32'h0, a, p, w, tmo, st);
        n_checks++; if (a !== RESET_PC || w !== mem_word(RESET_PC) || tmo !== 1'b0) begin n_fail++; $display("FAIL restart got addr=%h instr=%h exp=%h/%h", a, w, RESET_PC, mem_word(RESET_PC)); end
        $display("reset_in_wait restart addr=%h instr=%h", a, w);
        exp_pc = exp_pc + 32'd4;
    endtask

    task automatic test_misaligned();
        logic [31:0] a, p, w; bit tmo, st, bad;
        n_checks++; if (misaligned_o !== 1'b0) begin n_fail++; $display("FAIL pre_misaligned got=%b exp=0", misaligned_o); end
        do_fetch(0, 0, 0, 1'b0, 1'b1, 32'h42, a, p, w, tmo, st);
        n_checks++; if (a !== exp_pc || tmo !== 1'b0) begin n_fail++; $display("FAIL mis_fetch got=%h exp=%h", a, exp_pc); end
        bad = 0;
        imem_gnt_i = 1'b1; imem_rvalid_i = 1'b1; instr_ready_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (misaligned_o !== 1'b1 || imem_req_o !== 1'b0 || instr_valid_o !== 1'b0 || imem_addr_o !== exp_pc) bad = 1;
            @(posedge clk); #1;
        end
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; instr_ready_i = 1'b0;
        n_checks++; if (bad !== 1'b0) begin n_fail++; $display("FAIL fault_state got mis=%b req=%b valid=%b addr=%h exp 1/0/0/%h", misaligned_o, imem_req_o, instr_valid_o, imem_addr_o, exp_pc); end
        #2 reset = 1'b1; #1;
        n_checks++; if (misaligned_o !== 1'b0) begin n_fail++; $display("FAIL fault_reset got=%b exp=0", misaligned_o); end
        @(posedge clk); #1 reset = 1'b0;
        exp_pc = RESET_PC;
        do_fetch(0, 0, 0, 1'b0, 1'b0, 32'h0, a, p, w, tmo, st);
        n_checks++; if (a !== RESET_PC || p !== RESET_PC || tmo !== 1'b0) begin n_fail++; $display("FAIL post_fault got=%h/%h exp=%h", a, p, RESET_PC); end
        $display("misaligned fault cleared, restart addr=%h", a);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        test_reset();
        test_sequential();
        test_hold_branch();
        test_gnt_wrap();
        test_random();
        test_reset_in_wait();
        test_misaligned();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
